// File: rtl/mont_exp_pkg.sv
// Shared types for the Montgomery exponentiation sequencer: operand selects,
// write destinations, FSM states and the internal operation code.
package mont_exp_pkg;

  typedef enum logic [2:0] {
    OP_M   = 3'd0,
    OP_X   = 3'd1,
    OP_A   = 3'd2,
    OP_R2  = 3'd3,
    OP_ONE = 3'd4
  } op_sel_t;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_X    = 2'd1,
    DST_A    = 2'd2
  } dst_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    NEXT  = 3'd4,
    FIN   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    MM_INIT = 3'd0,
    MM_CONV = 3'd1,
    MM_SQ   = 3'd2,
    MM_MUL  = 3'd3,
    MM_POST = 3'd4
  } mm_op_t;

  function automatic op_sel_t sel_a_of(input mm_op_t op);
    op_sel_t sel;
    case (op)
      MM_INIT: sel = OP_R2;
      MM_CONV: sel = OP_M;
      MM_SQ:   sel = OP_A;
      MM_MUL:  sel = OP_A;
      MM_POST: sel = OP_A;
      default: sel = OP_ONE;
    endcase
    return sel;
  endfunction

  function automatic op_sel_t sel_b_of(input mm_op_t op);
    op_sel_t sel;
    case (op)
      MM_INIT: sel = OP_ONE;
      MM_CONV: sel = OP_R2;
      MM_SQ:   sel = OP_A;
      MM_MUL:  sel = OP_X;
      MM_POST: sel = OP_ONE;
      default: sel = OP_ONE;
    endcase
    return sel;
  endfunction

  // Only the base conversion lands in X; everything else accumulates into A.
  function automatic dst_t dst_of(input mm_op_t op);
    dst_t dst;
    case (op)
      MM_CONV: dst = DST_X;
      MM_INIT: dst = DST_A;
      MM_SQ:   dst = DST_A;
      MM_MUL:  dst = DST_A;
      MM_POST: dst = DST_A;
      default: dst = DST_NONE;
    endcase
    return dst;
  endfunction

endpackage

// File: rtl/exp_bit_scanner.sv
// Exponent shift register with bit-index counter: presents the current
// exponent bit (MSB first) and flags when the index has reached bit 0.
module exp_bit_scanner #(
  parameter int E = 1024
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_ce,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [E-1:0] i_exp,
  output logic         o_cur_bit,
  output logic         o_last_bit
);

  localparam int IW = (E > 1) ? $clog2(E) : 1;

  logic [E-1:0]  r_sr;
  logic [IW-1:0] r_idx;

  // Load on accepted start; shifting stops at bit 0 so the index never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr  <= {E{1'b0}};
      r_idx <= {IW{1'b0}};
    end else if (i_ce) begin
      if (i_load) begin
        r_sr  <= i_exp;
        r_idx <= IW'(E - 1);
      end else if (i_shift && (r_idx != {IW{1'b0}})) begin
        r_sr  <= r_sr << 1'b1;
        r_idx <= r_idx - IW'(1);
      end
    end
  end

  assign o_cur_bit  = r_sr[E-1];
  assign o_last_bit = (r_idx == {IW{1'b0}});

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery
// multiplier; all outputs are registered and frozen while ce is low.
module mont_exp_ctrl
  import mont_exp_pkg::*;
#(
  parameter int E = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         start,
  input  logic [E-1:0] exp,
  input  logic         mm_ready_next,
  output logic         mm_start,
  output logic [2:0]   mm_sel_a,
  output logic [2:0]   mm_sel_b,
  output logic         wr_en,
  output logic [1:0]   wr_dst,
  output logic         busy,
  output logic         done
);

  state_t  r_state;
  state_t  w_state_nxt;
  mm_op_t  r_op;
  mm_op_t  w_op_d;
  mm_op_t  w_op_after;
  logic    w_load;
  logic    w_shift;
  logic    w_cur_bit;
  logic    w_last_bit;

  logic    r_mm_start;
  logic    r_wr_en;
  logic    r_busy;
  logic    r_done;
  op_sel_t r_sel_a;
  op_sel_t r_sel_b;
  dst_t    r_wr_dst;
  logic    w_mm_start_d;
  logic    w_wr_en_d;
  logic    w_busy_d;
  logic    w_done_d;
  op_sel_t w_sel_a_d;
  op_sel_t w_sel_b_d;
  dst_t    w_wr_dst_d;

  exp_bit_scanner #(.E(E)) u_scan (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ce       (ce),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_exp      (exp),
    .o_cur_bit  (w_cur_bit),
    .o_last_bit (w_last_bit)
  );

  // State and current-operation registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= MM_INIT;
    end else if (ce) begin
      r_state <= w_state_nxt;
      r_op    <= w_op_d;
    end
  end

  // Next state, next operation and scanner control.
  always_comb begin
    w_state_nxt = r_state;
    w_op_after  = r_op;
    w_shift     = 1'b0;
    w_load      = (r_state == IDLE) && start;

    case (r_op)
      MM_INIT: w_op_after = MM_CONV;
      MM_CONV: w_op_after = MM_SQ;
      MM_SQ: begin
        if (w_cur_bit) begin
          w_op_after = MM_MUL;
        end else if (w_last_bit) begin
          w_op_after = MM_POST;
        end else begin
          w_op_after = MM_SQ;
          w_shift    = (r_state == NEXT);
        end
      end
      MM_MUL: begin
        if (w_last_bit) begin
          w_op_after = MM_POST;
        end else begin
          w_op_after = MM_SQ;
          w_shift    = (r_state == NEXT);
        end
      end
      MM_POST: w_op_after = MM_POST;
      default: w_op_after = MM_INIT;
    endcase

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (mm_ready_next) begin
          w_state_nxt = WRITE;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      WRITE: w_state_nxt = NEXT;
      NEXT: begin
        if (r_op == MM_POST) begin
          w_state_nxt = FIN;
        end else begin
          w_state_nxt = ISSUE;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    if (w_load) begin
      w_op_d = MM_INIT;
    end else if (r_state == NEXT) begin
      w_op_d = w_op_after;
    end else begin
      w_op_d = r_op;
    end
  end

  // Output values for the state being entered; operand selects only change
  // on entry to ISSUE so they stay stable through the matching WRITE.
  always_comb begin
    w_mm_start_d = (w_state_nxt == ISSUE);
    w_wr_en_d    = (w_state_nxt == WRITE);
    w_busy_d     = (w_state_nxt inside {ISSUE, WAIT, WRITE, NEXT});
    w_done_d     = (w_state_nxt == FIN);

    if (w_state_nxt == ISSUE) begin
      w_sel_a_d = sel_a_of(w_op_d);
      w_sel_b_d = sel_b_of(w_op_d);
    end else begin
      w_sel_a_d = r_sel_a;
      w_sel_b_d = r_sel_b;
    end

    if (w_state_nxt == WRITE) begin
      w_wr_dst_d = dst_of(r_op);
    end else begin
      w_wr_dst_d = DST_NONE;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mm_start <= 1'b0;
      r_wr_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sel_a    <= OP_ONE;
      r_sel_b    <= OP_ONE;
      r_wr_dst   <= DST_NONE;
    end else if (ce) begin
      r_mm_start <= w_mm_start_d;
      r_wr_en    <= w_wr_en_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_sel_a    <= w_sel_a_d;
      r_sel_b    <= w_sel_b_d;
      r_wr_dst   <= w_wr_dst_d;
    end
  end

  assign mm_start = r_mm_start;
  assign mm_sel_a = r_sel_a;
  assign mm_sel_b = r_sel_b;
  assign wr_en    = r_wr_en;
  assign wr_dst   = r_wr_dst;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: a small (E=4) and a large (E=1024) instance driven
// by a latency-configurable multiplier stand-in and checked against op lists.
module tb_mont_exp_ctrl;
  import mont_exp_pkg::*;

  localparam int ES = 4;
  localparam int EB = 1024;
  localparam int C_INIT = 0;
  localparam int C_CONV = 1;
  localparam int C_SQ   = 2;
  localparam int C_MUL  = 3;
  localparam int C_POST = 4;
  localparam int C_BAD  = 7;
  localparam logic [11:0] RST_SNAP = {1'b0, OP_ONE, OP_ONE, 1'b0, DST_NONE, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;
  logic s_start, b_start, s_rdy, b_rdy;
  logic [ES-1:0] s_exp;
  logic [EB-1:0] b_exp;
  logic s_mm_start, b_mm_start, s_wr_en, b_wr_en, s_busy, b_busy, s_done, b_done;
  logic [2:0] s_sel_a, s_sel_b, b_sel_a, b_sel_b;
  logic [1:0] s_wr_dst, b_wr_dst;

  logic m_start, m_wr_en, m_busy, m_done;
  logic [2:0] m_sel_a, m_sel_b;
  logic [1:0] m_wr_dst;

  int n_tests = 0;
  int n_fail  = 0;
  int act = 0;
  int lat = 1;
  bit pend = 1'b0;
  int cnt = 0;
  bit noise = 1'b0;
  int ops_q[$];
  int dst_q[$];
  int n_done = 0;
  int n_start = 0;
  int n_wr = 0;
  logic [2:0] cur_a, cur_b;

  always #5 clk = ~clk;

  mont_exp_ctrl #(.E(ES)) u_small (
    .clk(clk), .rst(rst), .ce(ce), .start(s_start), .exp(s_exp),
    .mm_ready_next(s_rdy), .mm_start(s_mm_start), .mm_sel_a(s_sel_a),
    .mm_sel_b(s_sel_b), .wr_en(s_wr_en), .wr_dst(s_wr_dst),
    .busy(s_busy), .done(s_done)
  );

  mont_exp_ctrl #(.E(EB)) u_big (
    .clk(clk), .rst(rst), .ce(ce), .start(b_start), .exp(b_exp),
    .mm_ready_next(b_rdy), .mm_start(b_mm_start), .mm_sel_a(b_sel_a),
    .mm_sel_b(b_sel_b), .wr_en(b_wr_en), .wr_dst(b_wr_dst),
    .busy(b_busy), .done(b_done)
  );

  always_comb begin
    if (act == 1) begin
      {m_start, m_sel_a, m_sel_b, m_wr_en, m_wr_dst, m_busy, m_done} =
        {b_mm_start, b_sel_a, b_sel_b, b_wr_en, b_wr_dst, b_busy, b_done};
    end else begin
      {m_start, m_sel_a, m_sel_b, m_wr_en, m_wr_dst, m_busy, m_done} =
        {s_mm_start, s_sel_a, s_sel_b, s_wr_en, s_wr_dst, s_busy, s_done};
    end
  end

  function automatic logic [11:0] snap();
    return {m_start, m_sel_a, m_sel_b, m_wr_en, m_wr_dst, m_busy, m_done};
  endfunction

  function automatic int op_of(input logic [2:0] a, input logic [2:0] b);
    if (a == OP_R2 && b == OP_ONE) return C_INIT;
    if (a == OP_M  && b == OP_R2)  return C_CONV;
    if (a == OP_A  && b == OP_A)   return C_SQ;
    if (a == OP_A  && b == OP_X)   return C_MUL;
    if (a == OP_A  && b == OP_ONE) return C_POST;
    return C_BAD;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Outputs present before an edge with ce=1 are consumed by the multiplier at that edge.
  task automatic tick();
    logic rdy;
    rdy = 1'b0;
    if (ce) begin
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          rdy  = 1'b1;
          pend = 1'b0;
        end
      end else if (noise) begin
        rdy = 1'($urandom_range(0, 1));
      end
      if (m_start === 1'b1) begin
        pend = 1'b1;
        cnt  = lat;
        n_start++;
        ops_q.push_back(op_of(m_sel_a, m_sel_b));
        cur_a = m_sel_a;
        cur_b = m_sel_b;
        check("busy_in_run", m_busy, 1);
      end
      if (m_wr_en === 1'b1) begin
        n_wr++;
        dst_q.push_back(int'(m_wr_dst));
        check("sel_a_hold", m_sel_a, cur_a);
        check("sel_b_hold", m_sel_b, cur_b);
      end
      if (m_done === 1'b1) n_done++;
    end
    if (act == 1) begin
      b_rdy = rdy;
      s_rdy = 1'b0;
    end else begin
      s_rdy = rdy;
      b_rdy = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic freeze(input string tag);
    logic [11:0] s0;
    s0 = snap();
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check(tag, snap(), s0);
    end
    ce = 1'b1;
  endtask

  // mode: 0 plain, 1 start pulse in first WAIT, 2 ce freezes, 3 reset in 5th WAIT
  task automatic run(input logic [EB-1:0] e, input int width, input int L,
                     input int mode, input int ce_pct);
    int exp_ops[$];
    int cyc;
    int bad;
    int n_wr0;
    bit did;
    bit did2;
    exp_ops = {};
    exp_ops.push_back(C_INIT);
    exp_ops.push_back(C_CONV);
    for (int i = width - 1; i >= 0; i--) begin
      exp_ops.push_back(C_SQ);
      if (e[i]) exp_ops.push_back(C_MUL);
    end
    exp_ops.push_back(C_POST);

    act = (width == EB) ? 1 : 0;
    lat = L;
    pend = 1'b0;
    ops_q = {};
    dst_q = {};
    n_done = 0;
    n_start = 0;
    n_wr = 0;
    s_exp = e[ES-1:0];
    b_exp = e;
    ce = 1'b1;
    if (act == 1) b_start = 1'b1;
    else s_start = 1'b1;
    tick();
    s_start = 1'b0;
    b_start = 1'b0;

    cyc = 0;
    did = 1'b0;
    did2 = 1'b0;
    while (n_done == 0 && cyc < 40000) begin
      cyc++;
      if (mode == 1 && pend && !did) begin
        did = 1'b1;
        ce = 1'b1;
        s_exp = ~e[ES-1:0];
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
      end else if (mode == 2 && pend && n_start == 3 && !did) begin
        did = 1'b1;
        freeze("freeze_wait");
      end else if (mode == 2 && m_wr_en && n_wr == 5 && !did2) begin
        did2 = 1'b1;
        freeze("freeze_write");
      end else if (mode == 3 && pend && n_start == 5) begin
        rst = 1'b1;
        ce = 1'b0;
        tick();
        rst = 1'b0;
        ce = 1'b1;
        pend = 1'b0;
        check("rst_outputs", snap(), RST_SNAP);
        n_wr0 = n_wr;
        repeat (6) tick();
        check("rst_no_wr", n_wr, n_wr0);
        check("rst_no_done", n_done, 0);
        check("rst_no_issue", n_start, 5);
        return;
      end else begin
        ce = ($urandom_range(0, 99) >= ce_pct);
        tick();
      end
    end
    ce = 1'b1;
    repeat (4) tick();

    check("done_once", n_done, 1);
    check("op_count", n_start, exp_ops.size());
    check("wr_count", n_wr, exp_ops.size());
    bad = -1;
    for (int i = 0; i < exp_ops.size(); i++) begin
      if (bad < 0 && (i >= ops_q.size() || ops_q[i] != exp_ops[i])) bad = i;
    end
    check("op_seq_first_bad", bad, -1);
    bad = -1;
    for (int i = 0; i < exp_ops.size(); i++) begin
      int want;
      want = (i == 1) ? int'(DST_X) : int'(DST_A);
      if (bad < 0 && (i >= dst_q.size() || dst_q[i] != want)) bad = i;
    end
    check("dst_seq_first_bad", bad, -1);
    check("last_op_post", (ops_q.size() > 0) ? ops_q[ops_q.size()-1] : C_BAD, C_POST);
    check("last_dst_a", (dst_q.size() > 0) ? dst_q[dst_q.size()-1] : C_BAD, int'(DST_A));
    check("busy_after", m_busy, 0);
  endtask

  initial begin
    logic [EB-1:0] ev;
    s_start = 1'b0;
    b_start = 1'b0;
    s_rdy = 1'b0;
    b_rdy = 1'b0;
    s_exp = {ES{1'b0}};
    b_exp = {EB{1'b0}};
    rst = 1'b1;
    ce = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    act = 0;
    #1;
    check("reset_outputs_small", snap(), RST_SNAP);
    act = 1;
    #1;
    check("reset_outputs_big", snap(), RST_SNAP);
    act = 0;
    #1;

    ev = {EB{1'b0}};
    ev[3:0] = 4'b1011;
    run(ev, ES, 5, 0, 0);

    ev[3:0] = 4'b0000;
    run(ev, ES, 5, 0, 0);

    ev[3:0] = 4'b0110;
    run(ev, ES, 3, 1, 0);

    ev[3:0] = 4'b1101;
    run(ev, ES, 3, 2, 0);

    ev[3:0] = 4'b1111;
    run(ev, ES, 2, 3, 0);
    ev[3:0] = 4'b0001;
    run(ev, ES, 2, 0, 0);

    noise = 1'b1;
    for (int r = 0; r < 8; r++) begin
      ev = {EB{1'b0}};
      ev[3:0] = 4'($urandom);
      run(ev, ES, $urandom_range(1, 6), 0, 25);
    end

    ev = {EB{1'b1}};
    run(ev, EB, 2, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
